instr_prefetch_queue: RTL and testbench
=======================================

// Module: instr_prefetch_queue
// PURPOSE
//  Parametrised instruction fetch unit with a prefetch FIFO between instruction memory and decoder.
//  Owns the fetch PC and issues one memory read at a time. Queues returned instructions with their PCs.
//  Absorbs memory and decoder stalls independently. Supports branch redirect with queue flush.
// PARAMETERS
//  ADDR_W   12     instruction memory address width (mem_addr = fetch_pc[ADDR_W-1:0])
//  INSTR_W  16     instruction width
//  PC_W     32     program counter width
//  DEPTH    4      prefetch queue entries, power of 2, >=2
//  PC_STEP  2      fetch PC increment per accepted request
//  RESET_PC 0      fetch PC after reset
// PORTS
//  clk            in   1        clock, rising edge
//  reset          in   1        asynchronous, active-high
//  mem_re         out  1        read request to instruction memory
//  mem_addr       out  ADDR_W   read address, valid while mem_re=1
//  mem_stall      in   1        memory busy: request not accepted / response not ready
//  mem_rdata      in   INSTR_W  read data, valid in RESP state when mem_stall=0
//  branch_valid   in   1        redirect request, single-cycle pulse
//  branch_target  in   PC_W     new fetch PC
//  dec_stall      in   1        decoder cannot accept this cycle
//  instr_valid    out  1        queue head valid
//  instr_out      out  INSTR_W  queue head instruction
//  instr_pc       out  PC_W     PC of queue head
//  queue_level    out  $clog2(DEPTH)+1  current entry count
// BEHAVIOUR
//  Reset (async, any state): state=BOOT, fetch_pc=RESET_PC, queue emptied.
//    mem_re=0, mem_addr=0, instr_valid=0, instr_out=0, instr_pc=0, queue_level=0.
//  FSM states: BOOT, REQ, RESP, DISCARD.
//  BOOT: mem_re=0; unconditionally -> REQ next cycle.
//  REQ: mem_re=1 iff queue_level<DEPTH; mem_addr=fetch_pc[ADDR_W-1:0].
//    Accept when mem_re=1 & mem_stall=0: capture req_pc=fetch_pc; fetch_pc+=PC_STEP (mod 2^PC_W); -> RESP.
//    Not accepted: stay in REQ, address held stable.
//  RESP: mem_re=0. If mem_stall=0: push {mem_rdata, req_pc}; -> REQ. Else stay.
//    Queue full cannot occur here: REQ only issues when space exists, so one slot is reserved.
//  Queue output: instr_valid = (queue_level!=0); instr_out/instr_pc = head, registered, no combinational path from mem.
//    Pop when instr_valid & !dec_stall. Push and pop in the same cycle: level unchanged.
//    Latency: accepted request -> response -> instr_valid on the next cycle (min. 2 cycles after acceptance).
//  Branch (branch_valid=1, any state except BOOT): highest priority.
//    Queue flushed, level=0 next cycle; a same-cycle push or pop is dropped.
//    fetch_pc=branch_target.
//    REQ: a same-cycle acceptance is cancelled -> REQ, no response expected; memory ignores de-asserted mem_re.
//      Exception: if mem_stall=0 and mem_re=1 in that cycle, the read is in flight -> DISCARD.
//    RESP: if mem_stall=0, the response is dropped -> REQ; else -> DISCARD.
//    DISCARD: mem_re=0; wait for mem_stall=0, drop data, -> REQ. A further branch here only updates fetch_pc.
//  Pointers wrap modulo DEPTH. queue_level ranges 0..DEPTH.
// TESTING
//  1. Reset, mem_stall=0, dec_stall=0 -> mem_addr 0,2,4,6...; instr_pc 0,2,4 in order, data matches memory model.
//  2. dec_stall=1 held 20 cycles -> queue_level reaches 4, mem_re=0 while full.
//     Release -> 4 pops on consecutive cycles, no loss or duplicate.
//  3. mem_stall=1 for 3 cycles in REQ, then 2 cycles in RESP -> mem_addr stable.
//     Single push after stall drops; fetch_pc advances exactly once.
//  4. branch_valid, target=0x100, issued in RESP with mem_stall=1 -> DISCARD; stale data dropped.
//     Next mem_addr=0x100; first instr_pc=0x100.
//  5. Branch with queue at 3 and dec_stall=0 -> instr_valid=0 next cycle, no old entry ever emitted.
//  6. Async reset asserted mid-RESP -> all outputs 0 immediately; after release, first fetch at RESET_PC.

Source files
------------

// File: rtl/instr_prefetch_queue_if.sv
// Fetch-unit bus bundle: instruction-memory read port, branch redirect and decoder-side queue head.
// master = fetch unit, slave = memory/decoder environment.
interface instr_prefetch_queue_if #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 16,
    parameter int PC_W    = 32,
    parameter int DEPTH   = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic               mem_re;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_stall;
    logic [INSTR_W-1:0] mem_rdata;
    logic               branch_valid;
    logic [PC_W-1:0]    branch_target;
    logic               dec_stall;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_out;
    logic [PC_W-1:0]    instr_pc;
    logic [LVL_W-1:0]   queue_level;

    modport master (
        output mem_re, mem_addr, instr_valid, instr_out, instr_pc, queue_level,
        input  mem_stall, mem_rdata, branch_valid, branch_target, dec_stall
    );

    modport slave (
        input  mem_re, mem_addr, instr_valid, instr_out, instr_pc, queue_level,
        output mem_stall, mem_rdata, branch_valid, branch_target, dec_stall
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction fetch unit: owns the fetch PC, keeps one memory read outstanding and queues
// returned instructions with their PCs; branches flush the queue and redirect fetch.
module instr_prefetch_queue #(
    parameter int              ADDR_W   = 12,
    parameter int              INSTR_W  = 16,
    parameter int              PC_W     = 32,
    parameter int              DEPTH    = 4,
    parameter int              PC_STEP  = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_prefetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {BOOT, REQ, RESP, DISCARD} state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]    req_pc_q, req_pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [INSTR_W-1:0] ent_instr_q [DEPTH];
    logic [INSTR_W-1:0] ent_instr_d [DEPTH];
    logic [PC_W-1:0]    ent_pc_q [DEPTH];
    logic [PC_W-1:0]    ent_pc_d [DEPTH];

    logic branch, mem_re, accept, push, pop, head_valid;

    // A read is only issued when a slot is free, so the response push never overflows.
    assign branch     = bus.branch_valid && (state_q != BOOT);
    assign head_valid = (level_q != '0);
    assign mem_re     = (state_q == REQ) && (level_q != LVL_W'(DEPTH));
    assign accept     = mem_re && !bus.mem_stall;
    assign push       = (state_q == RESP) && !bus.mem_stall && !branch;
    assign pop        = head_valid && !bus.dec_stall && !branch;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                if (accept) begin
                    // An accepted read is in flight even if a branch arrives with it.
                    state_d    = branch ? DISCARD : RESP;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + PC_W'(PC_STEP);
                end
            end
            RESP: begin
                if (!bus.mem_stall)  state_d = REQ;
                else if (branch)     state_d = DISCARD;
            end
            DISCARD: begin
                if (!bus.mem_stall)  state_d = REQ;
            end
            default: state_d = BOOT;
        endcase
        if (branch) fetch_pc_d = bus.branch_target;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        ent_instr_d = ent_instr_q;
        ent_pc_d    = ent_pc_q;
        if (branch) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                ent_instr_d[wr_ptr_q] = bus.mem_rdata;
                ent_pc_d[wr_ptr_q]    = req_pc_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_instr_q[i] <= '0;
                ent_pc_q[i]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ent_instr_q <= ent_instr_d;
            ent_pc_q    <= ent_pc_d;
        end
    end

    // Head is driven straight from the entry flops; zeroed when empty.
    assign bus.mem_re      = mem_re;
    assign bus.mem_addr    = (state_q == REQ) ? fetch_pc_q[ADDR_W-1:0] : '0;
    assign bus.instr_valid = head_valid;
    assign bus.instr_out   = head_valid ? ent_instr_q[rd_ptr_q] : '0;
    assign bus.instr_pc    = head_valid ? ent_pc_q[rd_ptr_q] : '0;
    assign bus.queue_level = level_q;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: streaming, decoder backpressure, memory stalls,
// branch redirects through DISCARD and asynchronous reset.
module tb_instr_prefetch_queue;
    localparam int ADDR_W  = 12;
    localparam int INSTR_W = 16;
    localparam int PC_W    = 32;
    localparam int DEPTH   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_prefetch_queue_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .PC_W(PC_W), .DEPTH(DEPTH)) bus ();

    instr_prefetch_queue #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .PC_W(PC_W), .DEPTH(DEPTH),
        .PC_STEP(2), .RESET_PC('0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory: latches the address of each accepted read; word content is 0xC000 | address.
    logic [ADDR_W-1:0] lat_addr;
    always @(posedge clk or posedge reset) begin
        if (reset) lat_addr <= '0;
        else if (bus.mem_re && !bus.mem_stall) lat_addr <= bus.mem_addr;
    end
    assign bus.mem_rdata = 16'hC000 | {4'h0, lat_addr};

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_dut();
        reset             = 1'b1;
        bus.mem_stall     = 1'b0;
        bus.dec_stall     = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time expired, want $finish before 100000");
        $fatal(1);
    end

    initial begin
        reset             = 1'b1;
        bus.mem_stall     = 1'b0;
        bus.dec_stall     = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = '0;
        #2;
        chk("rst_mem_re",  32'(bus.mem_re), 0);
        chk("rst_addr",    32'(bus.mem_addr), 0);
        chk("rst_valid",   32'(bus.instr_valid), 0);
        chk("rst_out",     32'(bus.instr_out), 0);
        chk("rst_pc",      bus.instr_pc, 0);
        chk("rst_level",   32'(bus.queue_level), 0);
        @(negedge clk);
        reset = 1'b0;

        // Streaming: one instruction per two cycles, popped as soon as it appears.
        cyc(1);
        chk("s_valid0", 32'(bus.instr_valid), 0);
        for (int k = 0; k < 4; k++) begin
            chk("s_mem_re", 32'(bus.mem_re), 1);
            chk("s_addr",   32'(bus.mem_addr), 32'(2 * k));
            if (k > 0) begin
                chk("s_valid", 32'(bus.instr_valid), 1);
                chk("s_pc",    bus.instr_pc, 32'(2 * (k - 1)));
                chk("s_out",   32'(bus.instr_out), 32'h0000C000 | 32'(2 * (k - 1)));
            end
            if (k < 3) cyc(2);
        end

        // Decoder backpressure: queue fills to DEPTH, then drains one per cycle.
        bus.dec_stall = 1'b1;
        cyc(20);
        chk("f_level",  32'(bus.queue_level), 4);
        chk("f_mem_re", 32'(bus.mem_re), 0);
        chk("f_addr",   32'(bus.mem_addr), 32'h00C);
        chk("f_valid",  32'(bus.instr_valid), 1);
        chk("f_pc0",    bus.instr_pc, 32'h4);
        bus.dec_stall = 1'b0;
        cyc(1);
        chk("d_pc1",    bus.instr_pc, 32'h6);
        chk("d_lvl1",   32'(bus.queue_level), 3);
        chk("d_mem_re", 32'(bus.mem_re), 1);
        cyc(1);
        chk("d_pc2",    bus.instr_pc, 32'h8);
        chk("d_lvl2",   32'(bus.queue_level), 2);
        cyc(1);
        chk("d_pc3",    bus.instr_pc, 32'hA);
        chk("d_lvl3",   32'(bus.queue_level), 2);
        cyc(1);
        chk("d_pc4",    bus.instr_pc, 32'hC);
        chk("d_out4",   32'(bus.instr_out), 32'hC00C);
        chk("d_lvl4",   32'(bus.queue_level), 1);

        // Memory stall: 3 cycles in REQ, 2 in RESP; address held, single push.
        reset_dut();
        bus.mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("ms_req_re",   32'(bus.mem_re), 1);
            chk("ms_req_addr", 32'(bus.mem_addr), 0);
        end
        bus.mem_stall = 1'b0;
        cyc(1);
        bus.mem_stall = 1'b1;
        cyc(1);
        chk("ms_resp_re",    32'(bus.mem_re), 0);
        chk("ms_resp_valid", 32'(bus.instr_valid), 0);
        cyc(1);
        bus.mem_stall = 1'b0;
        cyc(1);
        chk("ms_valid", 32'(bus.instr_valid), 1);
        chk("ms_pc",    bus.instr_pc, 0);
        chk("ms_out",   32'(bus.instr_out), 32'hC000);
        chk("ms_level", 32'(bus.queue_level), 1);
        chk("ms_addr",  32'(bus.mem_addr), 2);

        // Branch in RESP under stall -> DISCARD, stale data dropped.
        reset_dut();
        cyc(2);
        chk("b1_resp_re", 32'(bus.mem_re), 0);
        bus.mem_stall     = 1'b1;
        bus.branch_valid  = 1'b1;
        bus.branch_target = 32'h100;
        cyc(1);
        bus.branch_valid = 1'b0;
        chk("b1_disc_re", 32'(bus.mem_re), 0);
        cyc(1);
        chk("b1_disc_valid", 32'(bus.instr_valid), 0);
        bus.mem_stall = 1'b0;
        cyc(1);
        chk("b1_re",    32'(bus.mem_re), 1);
        chk("b1_addr",  32'(bus.mem_addr), 32'h100);
        chk("b1_valid", 32'(bus.instr_valid), 0);
        cyc(2);
        chk("b1_hvalid", 32'(bus.instr_valid), 1);
        chk("b1_pc",     bus.instr_pc, 32'h100);
        chk("b1_out",    32'(bus.instr_out), 32'hC100);

        // Branch with three queued entries and an accepted read in the same cycle.
        reset_dut();
        bus.dec_stall = 1'b1;
        cyc(7);
        chk("b2_level", 32'(bus.queue_level), 3);
        chk("b2_re",    32'(bus.mem_re), 1);
        chk("b2_addr",  32'(bus.mem_addr), 6);
        bus.dec_stall     = 1'b0;
        bus.branch_valid  = 1'b1;
        bus.branch_target = 32'h200;
        cyc(1);
        bus.branch_valid = 1'b0;
        chk("b2_flush_valid", 32'(bus.instr_valid), 0);
        chk("b2_flush_level", 32'(bus.queue_level), 0);
        chk("b2_disc_re",     32'(bus.mem_re), 0);
        cyc(1);
        chk("b2_re",    32'(bus.mem_re), 1);
        chk("b2_naddr", 32'(bus.mem_addr), 32'h200);
        chk("b2_valid", 32'(bus.instr_valid), 0);
        cyc(1);
        chk("b2_valid_resp", 32'(bus.instr_valid), 0);
        cyc(1);
        chk("b2_hvalid", 32'(bus.instr_valid), 1);
        chk("b2_pc",     bus.instr_pc, 32'h200);
        chk("b2_out",    32'(bus.instr_out), 32'hC200);

        // Asynchronous reset in the middle of RESP.
        reset_dut();
        bus.dec_stall = 1'b1;
        cyc(4);
        chk("ar_pre_level", 32'(bus.queue_level), 1);
        chk("ar_pre_out",   32'(bus.instr_out), 32'hC000);
        chk("ar_pre_re",    32'(bus.mem_re), 0);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_mem_re", 32'(bus.mem_re), 0);
        chk("ar_addr",   32'(bus.mem_addr), 0);
        chk("ar_valid",  32'(bus.instr_valid), 0);
        chk("ar_out",    32'(bus.instr_out), 0);
        chk("ar_pc",     bus.instr_pc, 0);
        chk("ar_level",  32'(bus.queue_level), 0);
        @(negedge clk);
        reset         = 1'b0;
        bus.dec_stall = 1'b0;
        cyc(1);
        chk("ar_post_re",   32'(bus.mem_re), 1);
        chk("ar_post_addr", 32'(bus.mem_addr), 0);
        cyc(2);
        chk("ar_post_pc",  bus.instr_pc, 0);
        chk("ar_post_out", 32'(bus.instr_out), 32'hC000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
